// File: rtl/fpu_req_scheduler.sv
// fpu_req_scheduler
//
// Front end that shares one in-order, pipelined FP16 add/mul core between two requesters.
// Requests (ADD/SUB/MULT) arrive over valid/ready, are arbitrated round-robin and issued to the
// core one per cycle through a registered issue stage. Every accepted request leaves a tag
// {requester_id, err} in a small FIFO. Core results, which come back in issue order, pop the head
// tag and are routed to the requester named in it. Unsupported opcodes are never issued: their
// tag is answered with an error response once it reaches the FIFO head.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req{0,1}_valid/ready       request handshake (accepted when valid & ready)
//   req{0,1}_op                3'b000 ADD, 3'b001 SUB, 3'b010 MULT, anything else unsupported
//   req{0,1}_a, req{0,1}_b     FP16 operands
//   rsp{0,1}_valid             one-cycle response pulse
//   rsp{0,1}_data, _err        FP16 result / unsupported-op flag (held while valid is low)
//   dp_valid, dp_op            issue strobe and operation (0 add, 1 mul) to the core
//   dp_a, dp_b                 core operands (dp_b sign already flipped for SUB)
//   dp_rvalid, dp_result       core result strobe and data, in issue order
//   busy                       tags outstanding or an issue in progress

module fpu_req_scheduler #(
  // Tag FIFO depth = max accepted-but-unanswered ops. Must be a power of two, >= 2.
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,

  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic        rsp1_err,

  output logic        dp_valid,
  output logic        dp_op,
  output logic [15:0] dp_a,
  output logic [15:0] dp_b,
  input  logic        dp_rvalid,
  input  logic [15:0] dp_result,

  output logic        busy
);

  localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_INFLIGHT);

  localparam logic [2:0]  OpAdd  = 3'b000;
  localparam logic [2:0]  OpSub  = 3'b001;
  localparam logic [2:0]  OpMul  = 3'b010;
  localparam logic [15:0] ErrNaN = 16'h7E00;

  // ---------------------------------------------------------------------------------------------
  // Tag FIFO state
  // ---------------------------------------------------------------------------------------------
  logic [CntW-1:0]         count_q, count_d;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [MAX_INFLIGHT-1:0] tag_id_q;
  logic [MAX_INFLIGHT-1:0] tag_err_q;

  // Requester that wins a tie; points away from the most recent grant.
  logic prio_q;

  logic fifo_full, fifo_empty;
  logic head_id, head_err;
  logic push, pop;

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign head_id    = tag_id_q[rd_ptr_q];
  assign head_err   = tag_err_q[rd_ptr_q];

  // ---------------------------------------------------------------------------------------------
  // Arbitration. Ready looks only at the valids, registered occupancy and the pointer, so a pop
  // in the same cycle never re-opens a full FIFO.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!fifo_full) begin
      req0_ready = req0_valid & (~req1_valid | ~prio_q);
      req1_ready = req1_valid & (~req0_valid |  prio_q);
    end
  end

  logic        accept;
  logic        grant_id;
  logic [2:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic        sel_err;
  logic        sel_issue;

  assign accept   = req0_ready | req1_ready;
  assign grant_id = req1_ready;

  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (grant_id) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  always_comb begin
    sel_err = 1'b1;
    unique case (sel_op)
      OpAdd, OpSub, OpMul: sel_err = 1'b0;
      default:             sel_err = 1'b1;
    endcase
  end

  assign sel_issue = accept & ~sel_err;

  // ---------------------------------------------------------------------------------------------
  // Result path. A core result always belongs to the head tag. An error tag at the head is
  // answered on its own; the core cannot return a result while an error tag sits at the head,
  // because everything ahead of it has already been answered.
  // ---------------------------------------------------------------------------------------------
  assign push = accept;
  assign pop  = ~fifo_empty & (dp_rvalid | head_err);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  logic [15:0] rsp_data_nxt;
  logic        rsp_err_nxt;

  always_comb begin
    rsp_data_nxt = dp_result;
    rsp_err_nxt  = 1'b0;
    if (!dp_rvalid) begin
      rsp_data_nxt = ErrNaN;
      rsp_err_nxt  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_id_q   <= '0;
      tag_err_q  <= '0;
      prio_q     <= 1'b0;
      dp_valid   <= 1'b0;
      dp_op      <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      count_q <= count_d;

      if (push) begin
        tag_id_q[wr_ptr_q]  <= grant_id;
        tag_err_q[wr_ptr_q] <= sel_err;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
        prio_q              <= ~grant_id;
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      // Issue stage: operands only move on a real issue, otherwise they hold.
      dp_valid <= sel_issue;
      if (sel_issue) begin
        dp_op <= (sel_op == OpMul);
        dp_a  <= sel_a;
        dp_b  <= (sel_op == OpSub) ? {~sel_b[15], sel_b[14:0]} : sel_b;
      end

      rsp0_valid <= pop & ~head_id;
      rsp1_valid <= pop &  head_id;
      if (pop && !head_id) begin
        rsp0_data <= rsp_data_nxt;
        rsp0_err  <= rsp_err_nxt;
      end
      if (pop && head_id) begin
        rsp1_data <= rsp_data_nxt;
        rsp1_err  <= rsp_err_nxt;
      end
    end
  end

  assign busy = ~fifo_empty | dp_valid;

endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Bench for fpu_req_scheduler: directed requests with hand-computed core results. Stimulus pushes
// expected issues and responses into queues; a monitor pops and compares when the DUT presents
// dp_valid or an rsp pulse. A small core model returns results a fixed latency after issue and
// can be stalled.

module tb_fpu_req_scheduler;

  localparam int unsigned MaxInflight = 4;

  typedef struct {
    logic        port;
    logic [15:0] data;
    logic        err;
    int          cyc;   // -1: arrival cycle not checked
  } rsp_exp_t;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } iss_exp_t;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp0_data, rsp1_data;
  logic        dp_valid, dp_op, dp_rvalid, busy;
  logic [15:0] dp_a, dp_b, dp_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          core_lat    = 3;
  logic        stall       = 1'b0;
  int          release_one = 0;
  int          inflight_q[$];
  logic [15:0] core_res_q[$];
  rsp_exp_t    rsp_q[$];
  iss_exp_t    iss_q[$];

  fpu_req_scheduler #(
    .MAX_INFLIGHT(MaxInflight)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .dp_valid   (dp_valid),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_rvalid  (dp_rvalid),
    .dp_result  (dp_result),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: issues and responses are checked against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (dp_valid) begin
        inflight_q.push_back(cyc + core_lat);
        if (iss_q.size() == 0) begin
          fail("unexpected_issue");
        end else begin
          iss_exp_t e;
          e = iss_q.pop_front();
          chk("dp_op", 32'(dp_op), 32'(e.op));
          chk("dp_a", 32'(dp_a), 32'(e.a));
          chk("dp_b", 32'(dp_b), 32'(e.b));
          chk("dp_cycle", cyc, e.cyc);
        end
      end
      if (rsp0_valid && rsp1_valid) begin
        fail("rsp_both_ports");
      end else if (rsp0_valid || rsp1_valid) begin
        if (rsp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          chk("rsp_port", 32'(rsp1_valid), 32'(r.port));
          chk("rsp_data", 32'(rsp1_valid ? rsp1_data : rsp0_data), 32'(r.data));
          chk("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(r.err));
          if (r.cyc >= 0) chk("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  // Core model: in-order, fixed latency, optionally stalled (release_one lets single results out).
  initial begin
    dp_rvalid = 1'b0;
    dp_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (inflight_q.size() > 0 && cyc >= inflight_q[0] && (!stall || release_one > 0)) begin
        dp_rvalid = 1'b1;
        dp_result = core_res_q.pop_front();
        void'(inflight_q.pop_front());
        if (stall) release_one--;
      end else begin
        dp_rvalid = 1'b0;
      end
    end
  end

  task automatic set_req(input bit p, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (!p) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Records the expectations of a request the DUT accepted in the current cycle.
  task automatic accept(input bit p, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] res);
    rsp_exp_t r;
    iss_exp_t e;
    r.port = p;
    if (op > 3'd2) begin
      r.data = 16'h7E00;
      r.err  = 1'b1;
      r.cyc  = (rsp_q.size() == 0) ? cyc + 2 : -1;
    end else begin
      e.op  = (op == 3'd2);
      e.a   = a;
      e.b   = (op == 3'd1) ? {~b[15], b[14:0]} : b;
      e.cyc = cyc + 1;
      iss_q.push_back(e);
      core_res_q.push_back(res);
      r.data = res;
      r.err  = 1'b0;
      r.cyc  = -1;
    end
    rsp_q.push_back(r);
  endtask

  task automatic send(input bit p, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] res);
    bit done = 0;
    set_req(p, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) begin
        accept(p, op, a, b, res);
        done = 1;
      end
    end
    if (!done) fail("send_timeout");
    @(posedge clk);
    #1;
    set_req(p, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && iss_q.size() == 0 && inflight_q.size() == 0 && !busy) done = 1;
    end
    if (!done) begin
      fail("drain_timeout");
      rsp_q.delete();
      iss_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Contention table: two ops per requester with hand-computed FP16 results.
  logic [2:0]  t_op [2][2];
  logic [15:0] t_a  [2][2];
  logic [15:0] t_b  [2][2];
  logic [15:0] t_res[2][2];

  initial begin
    int idx[2];
    int grants[$];
    int acc_cyc[$];
    int nacc;
    int last_p;

    t_op[0][0] = 3'd0; t_a[0][0] = 16'h3C00; t_b[0][0] = 16'h3C00; t_res[0][0] = 16'h4000;
    t_op[0][1] = 3'd2; t_a[0][1] = 16'h4000; t_b[0][1] = 16'h4200; t_res[0][1] = 16'h4600;
    t_op[1][0] = 3'd1; t_a[1][0] = 16'h4400; t_b[1][0] = 16'h3C00; t_res[1][0] = 16'h4200;
    t_op[1][1] = 3'd0; t_a[1][1] = 16'h4000; t_b[1][1] = 16'h4000; t_res[1][1] = 16'h4400;

    set_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_dp_a", 32'(dp_a), 0);
    chk("rst_dp_b", 32'(dp_b), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp0_data", 32'(rsp0_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;

    // Single ADD: 1.0 + 2.0 = 3.0
    send(0, 3'd0, 16'h3C00, 16'h4000, 16'h4200);
    drain();

    // MULT on req0 (2.0*2.0), then SUB on req1 (4.0-1.0)
    send(0, 3'd2, 16'h4000, 16'h4000, 16'h4400);
    send(1, 3'd1, 16'h4400, 16'h3C00, 16'h4200);
    drain();

    // Contention: last grant was req1, so grants must go 0,1,0,1 on consecutive cycles.
    idx[0] = 0;
    idx[1] = 0;
    set_req(0, 1'b1, t_op[0][0], t_a[0][0], t_b[0][0]);
    set_req(1, 1'b1, t_op[1][0], t_a[1][0], t_b[1][0]);
    for (int k = 0; k < 20 && (idx[0] < 2 || idx[1] < 2); k++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) fail("both_ready");
      if (req0_ready) begin
        accept(0, t_op[0][idx[0]], t_a[0][idx[0]], t_b[0][idx[0]], t_res[0][idx[0]]);
        grants.push_back(0);
        acc_cyc.push_back(cyc);
        idx[0]++;
      end else if (req1_ready) begin
        accept(1, t_op[1][idx[1]], t_a[1][idx[1]], t_b[1][idx[1]], t_res[1][idx[1]]);
        grants.push_back(1);
        acc_cyc.push_back(cyc);
        idx[1]++;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        int j;
        j = (idx[p] < 2) ? idx[p] : 1;
        set_req(p[0], idx[p] < 2, t_op[p][j], t_a[p][j], t_b[p][j]);
      end
    end
    set_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
    chk("grant_count", grants.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("grant_order", (grants.size() > k) ? grants[k] : 99, k % 2);
    end
    if (acc_cyc.size() == 4) chk("grant_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
    drain();

    // Backpressure: core stalled, four req0 ops fill the FIFO.
    stall = 1'b1;
    send(0, 3'd0, 16'h3C00, 16'h3C00, 16'h4000);
    send(0, 3'd0, 16'h4000, 16'h4000, 16'h4400);
    send(0, 3'd0, 16'h4200, 16'h3C00, 16'h4400);
    send(0, 3'd0, 16'h4400, 16'h4000, 16'h4600);
    set_req(0, 1'b1, 3'd0, 16'h3C00, 16'h4000);
    set_req(1, 1'b1, 3'd1, 16'h4200, 16'h3C00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_req0_ready", 32'(req0_ready), 0);
      chk("full_req1_ready", 32'(req1_ready), 0);
      @(posedge clk);
      #1;
    end
    chk("full_busy", 32'(busy), 1);
    release_one = 1;
    nacc = 0;
    last_p = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req0_ready) begin
        accept(0, 3'd0, 16'h3C00, 16'h4000, 16'h4200);
        nacc++;
        last_p = 0;
      end else if (req1_ready) begin
        accept(1, 3'd1, 16'h4200, 16'h3C00, 16'h4000);
        nacc++;
        last_p = 1;
      end
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
    chk("bp_one_accept", nacc, 1);
    chk("bp_grant_req1", last_p, 1);
    stall = 1'b0;
    drain();

    // Unsupported op alone: error response two cycles after acceptance, no issue.
    send(0, 3'd3, 16'h1234, 16'h5678, 16'h0);
    drain();
    // Unsupported op queued behind two real ops.
    send(0, 3'd0, 16'h3C00, 16'h4000, 16'h4200);
    send(1, 3'd2, 16'h4200, 16'h4000, 16'h4600);
    send(0, 3'd7, 16'hAAAA, 16'h5555, 16'h0);
    drain();

    // Reset mid-flight: three ops stuck in the stalled core, then reset.
    stall = 1'b1;
    send(0, 3'd0, 16'h3C00, 16'h3C00, 16'h4000);
    send(0, 3'd0, 16'h3C00, 16'h3C00, 16'h4000);
    send(0, 3'd0, 16'h3C00, 16'h3C00, 16'h4000);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_q.delete();
    chk("rst_iss_left", iss_q.size(), 0);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp0_data", 32'(rsp0_data), 0);
    chk("midrst_dp_a", 32'(dp_a), 0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_core_drained", inflight_q.size(), 0);
    chk("post_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 3'd0, 16'h3C00, 16'h4000);
    set_req(1, 1'b1, 3'd0, 16'h4000, 16'h4000);
    @(negedge clk);
    chk("post_rst_req0_ready", 32'(req0_ready), 1);
    chk("post_rst_req1_ready", 32'(req1_ready), 0);
    if (req0_ready) accept(0, 3'd0, 16'h3C00, 16'h4000, 16'h4200);
    else if (req1_ready) accept(1, 3'd0, 16'h4000, 16'h4000, 16'h4400);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 3'd0, 16'h0, 16'h0);
    set_req(1, 1'b0, 3'd0, 16'h0, 16'h0);
    drain();

    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("iss_q_empty", iss_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
